// File: rtl/hazard_forwarding_unit_if.sv
// Pipeline-to-hazard-unit bundle: register ids, write enables,
// branch/annul/RAM status in; forwarding selects and pipeline controls out.
interface hazard_forwarding_unit_if;
  logic [4:0]  ID_RS1;
  logic [4:0]  ID_RS2;
  logic        ID_Use_RS1;
  logic        ID_Use_RS2;
  logic [4:0]  EX_RD;
  logic        EX_RF_Enable;
  logic        EX_Load_Instr;
  logic [4:0]  MEM_RD;
  logic        MEM_RF_Enable;
  logic [4:0]  WB_RD;
  logic        WB_RF_Enable;
  logic        EX_Branch_Taken;
  logic        EX_Annul_Delay;
  logic        MEM_RAM_Enable;
  logic        RAM_Ready;
  logic [1:0]  FWD_A;
  logic [1:0]  FWD_B;
  logic        Front_Enable;
  logic        Back_Enable;
  logic        CU_Nop_Select;
  logic        IF_ID_Clear;
  logic        Branch_Select;
  logic        Mem_Fault;
  logic [15:0] Stall_Count;

  modport master (
    output ID_RS1, ID_RS2, ID_Use_RS1, ID_Use_RS2,
    output EX_RD, EX_RF_Enable, EX_Load_Instr,
    output MEM_RD, MEM_RF_Enable, WB_RD, WB_RF_Enable,
    output EX_Branch_Taken, EX_Annul_Delay,
    output MEM_RAM_Enable, RAM_Ready,
    input  FWD_A, FWD_B, Front_Enable, Back_Enable,
    input  CU_Nop_Select, IF_ID_Clear, Branch_Select,
    input  Mem_Fault, Stall_Count
  );

  modport slave (
    input  ID_RS1, ID_RS2, ID_Use_RS1, ID_Use_RS2,
    input  EX_RD, EX_RF_Enable, EX_Load_Instr,
    input  MEM_RD, MEM_RF_Enable, WB_RD, WB_RF_Enable,
    input  EX_Branch_Taken, EX_Annul_Delay,
    input  MEM_RAM_Enable, RAM_Ready,
    output FWD_A, FWD_B, Front_Enable, Back_Enable,
    output CU_Nop_Select, IF_ID_Clear, Branch_Select,
    output Mem_Fault, Stall_Count
  );
endinterface

// File: rtl/hazard_forwarding_unit.sv
// Operand forwarding, load-use bubble, branch flush and data-RAM
// wait/timeout freeze for a 5-stage pipeline.
module hazard_forwarding_unit (
  input  logic clk,
  input  logic reset,
  hazard_forwarding_unit_if.slave hif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [3:0]  wait_q;
  logic [3:0]  wait_d;
  logic [15:0] stall_q;
  logic        fault_q;

  logic        frozen;
  logic        load_use;
  logic [1:0]  fwd_a_raw;
  logic [1:0]  fwd_b_raw;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic        front_en;
  logic        back_en;
  logic        nop_sel;
  logic        ifid_clr;
  logic        br_sel;

  function automatic logic [1:0] fwd_sel(
    input logic       use_rs,
    input logic [4:0] rs,
    input logic [4:0] ex_rd,
    input logic       ex_we,
    input logic [4:0] mem_rd,
    input logic       mem_we,
    input logic [4:0] wb_rd,
    input logic       wb_we
  );
    logic live;
    logic ex_hit;
    logic mem_hit;
    logic wb_hit;
    logic [1:0] sel;
    // r0 is hardwired zero, so it is never a forwarding source
    live    = use_rs && (rs != 5'd0);
    ex_hit  = live && ex_we && (ex_rd == rs);
    mem_hit = live && mem_we && (mem_rd == rs) && !ex_hit;
    wb_hit  = live && wb_we && (wb_rd == rs) && !ex_hit && !mem_hit;
    sel = 2'b00;
    unique case (1'b1)
      ex_hit:  sel = 2'b01;
      mem_hit: sel = 2'b10;
      wb_hit:  sel = 2'b11;
      default: sel = 2'b00;
    endcase
    return sel;
  endfunction

  assign fwd_a_raw = fwd_sel(
    hif.ID_Use_RS1, hif.ID_RS1,
    hif.EX_RD, hif.EX_RF_Enable,
    hif.MEM_RD, hif.MEM_RF_Enable,
    hif.WB_RD, hif.WB_RF_Enable
  );

  assign fwd_b_raw = fwd_sel(
    hif.ID_Use_RS2, hif.ID_RS2,
    hif.EX_RD, hif.EX_RF_Enable,
    hif.MEM_RD, hif.MEM_RF_Enable,
    hif.WB_RD, hif.WB_RF_Enable
  );

  assign load_use = hif.EX_Load_Instr &&
                    ((fwd_a_raw == 2'b01) || (fwd_b_raw == 2'b01));

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    frozen  = 1'b0;
    unique case (state_q)
      RUN: begin
        if (hif.MEM_RAM_Enable && !hif.RAM_Ready) begin
          frozen  = 1'b1;
          state_d = MEM_WAIT;
          wait_d  = 4'd1;
        end
      end
      MEM_WAIT: begin
        if (hif.RAM_Ready) begin
          state_d = RUN;
          wait_d  = 4'd0;
        end else begin
          frozen = 1'b1;
          // wait_q counts frozen cycles already spent; 16 is the limit
          if (wait_q == 4'd15) begin
            state_d = FAULT;
          end else begin
            wait_d = wait_q + 4'd1;
          end
        end
      end
      FAULT: begin
        frozen = 1'b1;
      end
      default: begin
        state_d = RUN;
        wait_d  = 4'd0;
      end
    endcase
  end

  always_comb begin
    fwd_a    = fwd_a_raw;
    fwd_b    = fwd_b_raw;
    front_en = 1'b1;
    back_en  = 1'b1;
    nop_sel  = 1'b0;
    ifid_clr = 1'b0;
    br_sel   = 1'b0;
    // freeze wins over branch and load-use; the frozen
    // pipeline registers keep those conditions for later
    if (reset) begin
      fwd_a    = 2'b00;
      fwd_b    = 2'b00;
      front_en = 1'b0;
      back_en  = 1'b0;
    end else if (frozen) begin
      front_en = 1'b0;
      back_en  = 1'b0;
    end else if (hif.EX_Branch_Taken) begin
      br_sel   = 1'b1;
      ifid_clr = 1'b1;
      nop_sel  = hif.EX_Annul_Delay;
    end else if (load_use) begin
      front_en = 1'b0;
      nop_sel  = 1'b1;
    end else begin
      nop_sel  = hif.EX_Annul_Delay;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      wait_q  <= 4'd0;
      stall_q <= 16'd0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (!front_en && (stall_q != 16'hFFFF)) begin
        stall_q <= stall_q + 16'd1;
      end
      if (state_d == FAULT) begin
        fault_q <= 1'b1;
      end
    end
  end

  assign hif.FWD_A         = fwd_a;
  assign hif.FWD_B         = fwd_b;
  assign hif.Front_Enable  = front_en;
  assign hif.Back_Enable   = back_en;
  assign hif.CU_Nop_Select = nop_sel;
  assign hif.IF_ID_Clear   = ifid_clr;
  assign hif.Branch_Select = br_sel;
  assign hif.Mem_Fault     = fault_q;
  assign hif.Stall_Count   = stall_q;

endmodule

// File: tb/tb_hazard_forwarding_unit.sv
// Scoreboard bench for hazard_forwarding_unit: directed scenarios
// followed by constrained-random traffic against a behavioural model.
module tb_hazard_forwarding_unit;

  logic clk;
  logic reset;

  hazard_forwarding_unit_if hif ();

  hazard_forwarding_unit dut (
    .clk   (clk),
    .reset (reset),
    .hif   (hif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] exrd;
    logic       exrf;
    logic       exld;
    logic [4:0] memrd;
    logic       memrf;
    logic [4:0] wbrd;
    logic       wbrf;
    logic       br;
    logic       ann;
    logic       ramen;
    logic       rdy;
  } stim_t;

  typedef struct packed {
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        fe;
    logic        be;
    logic        nop;
    logic        clr;
    logic        bsel;
    logic        flt;
    logic [15:0] sc;
  } exp_t;

  exp_t expq[$];

  int n_chk = 0;
  int n_err = 0;

  int          m_state = 0;
  int          m_wcnt  = 0;
  logic [15:0] m_stall = 16'd0;
  logic        m_fault = 1'b0;

  stim_t s;

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] mfwd(input logic u, input logic [4:0] rs,
                                      input stim_t st);
    if (!u || rs == 5'd0) return 2'b00;
    if (st.exrf && st.exrd == rs) return 2'b01;
    if (st.memrf && st.memrd == rs) return 2'b10;
    if (st.wbrf && st.wbrd == rs) return 2'b11;
    return 2'b00;
  endfunction

  task automatic step(input stim_t st);
    exp_t       e;
    exp_t       o;
    logic       frz;
    logic       lu;
    logic [1:0] fa;
    logic [1:0] fb;
    @(posedge clk);
    #1;
    reset               = st.rst;
    hif.ID_RS1          = st.rs1;
    hif.ID_RS2          = st.rs2;
    hif.ID_Use_RS1      = st.u1;
    hif.ID_Use_RS2      = st.u2;
    hif.EX_RD           = st.exrd;
    hif.EX_RF_Enable    = st.exrf;
    hif.EX_Load_Instr   = st.exld;
    hif.MEM_RD          = st.memrd;
    hif.MEM_RF_Enable   = st.memrf;
    hif.WB_RD           = st.wbrd;
    hif.WB_RF_Enable    = st.wbrf;
    hif.EX_Branch_Taken = st.br;
    hif.EX_Annul_Delay  = st.ann;
    hif.MEM_RAM_Enable  = st.ramen;
    hif.RAM_Ready       = st.rdy;

    fa  = mfwd(st.u1, st.rs1, st);
    fb  = mfwd(st.u2, st.rs2, st);
    frz = (m_state == 2) ||
          (m_state == 0 && st.ramen && !st.rdy) ||
          (m_state == 1 && !st.rdy);
    lu  = st.exld && (fa == 2'b01 || fb == 2'b01);
    e     = '0;
    e.flt = m_fault;
    e.sc  = m_stall;
    if (!st.rst) begin
      e.fa = fa;
      e.fb = fb;
      if (!frz) begin
        e.be   = 1'b1;
        e.fe   = st.br || !lu;
        e.bsel = st.br;
        e.clr  = st.br;
        e.nop  = st.ann || (lu && !st.br);
      end
    end
    expq.push_back(e);

    @(negedge clk);
    o = expq.pop_front();
    chk("fwd_a", {14'd0, hif.FWD_A}, {14'd0, o.fa});
    chk("fwd_b", {14'd0, hif.FWD_B}, {14'd0, o.fb});
    chk("front_en", {15'd0, hif.Front_Enable}, {15'd0, o.fe});
    chk("back_en", {15'd0, hif.Back_Enable}, {15'd0, o.be});
    chk("nop_sel", {15'd0, hif.CU_Nop_Select}, {15'd0, o.nop});
    chk("ifid_clr", {15'd0, hif.IF_ID_Clear}, {15'd0, o.clr});
    chk("br_sel", {15'd0, hif.Branch_Select}, {15'd0, o.bsel});
    chk("mem_fault", {15'd0, hif.Mem_Fault}, {15'd0, o.flt});
    chk("stall_cnt", hif.Stall_Count, o.sc);

    if (st.rst) begin
      m_state = 0;
      m_wcnt  = 0;
      m_stall = 16'd0;
      m_fault = 1'b0;
    end else begin
      if (!e.fe && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
      case (m_state)
        0: if (st.ramen && !st.rdy) begin
          m_state = 1;
          m_wcnt  = 1;
        end
        1: if (st.rdy) begin
          m_state = 0;
          m_wcnt  = 0;
        end else if (m_wcnt == 15) begin
          m_state = 2;
          m_fault = 1'b1;
        end else begin
          m_wcnt = m_wcnt + 1;
        end
        default: ;
      endcase
    end
  endtask

  task automatic idle();
    s     = '0;
    s.rdy = 1'b1;
  endtask

  task automatic do_reset();
    idle();
    s.rst = 1'b1;
    step(s);
    s.rst = 1'b0;
  endtask

  initial begin
    reset               = 1'b1;
    hif.ID_RS1          = '0;
    hif.ID_RS2          = '0;
    hif.ID_Use_RS1      = 1'b0;
    hif.ID_Use_RS2      = 1'b0;
    hif.EX_RD           = '0;
    hif.EX_RF_Enable    = 1'b0;
    hif.EX_Load_Instr   = 1'b0;
    hif.MEM_RD          = '0;
    hif.MEM_RF_Enable   = 1'b0;
    hif.WB_RD           = '0;
    hif.WB_RF_Enable    = 1'b0;
    hif.EX_Branch_Taken = 1'b0;
    hif.EX_Annul_Delay  = 1'b0;
    hif.MEM_RAM_Enable  = 1'b0;
    hif.RAM_Ready       = 1'b1;

    do_reset();
    step(s);
    chk("post_rst_fe", {15'd0, hif.Front_Enable}, 16'd1);

    // EX and MEM both hold r5: EX wins, then MEM once EX_RD is r0
    s.rs1 = 5'd5; s.u1 = 1'b1;
    s.exrd = 5'd5; s.exrf = 1'b1;
    s.memrd = 5'd5; s.memrf = 1'b1;
    step(s);
    chk("ex_prio", {14'd0, hif.FWD_A}, 16'd1);
    s.exrd = 5'd0;
    step(s);
    chk("mem_fwd", {14'd0, hif.FWD_A}, 16'd2);
    s.memrf = 1'b0; s.wbrd = 5'd5; s.wbrf = 1'b1;
    s.rs2 = 5'd5; s.u2 = 1'b1;
    step(s);
    chk("wb_fwd_b", {14'd0, hif.FWD_B}, 16'd3);
    s.rs1 = 5'd0; s.exrd = 5'd0; s.wbrd = 5'd0;
    step(s);

    do_reset();
    s.exld = 1'b1; s.exrd = 5'd3; s.exrf = 1'b1;
    s.rs2 = 5'd3; s.u2 = 1'b1;
    step(s);
    chk("lu_nop", {15'd0, hif.CU_Nop_Select}, 16'd1);
    s.exld = 1'b0; s.exrf = 1'b0; s.exrd = 5'd0;
    s.memrd = 5'd3; s.memrf = 1'b1;
    step(s);
    chk("lu_sc", hif.Stall_Count, 16'd1);
    chk("lu_fwd_b", {14'd0, hif.FWD_B}, 16'd2);

    // taken branch with annulled delay slot, then with a load-use pending
    idle();
    s.br = 1'b1; s.ann = 1'b1;
    step(s);
    chk("br_nop", {15'd0, hif.CU_Nop_Select}, 16'd1);
    s.ann = 1'b0; s.exld = 1'b1; s.exrd = 5'd7; s.exrf = 1'b1;
    s.rs1 = 5'd7; s.u1 = 1'b1;
    step(s);
    chk("br_over_lu", {15'd0, hif.Front_Enable}, 16'd1);

    do_reset();
    s.ramen = 1'b1; s.rdy = 1'b0;
    repeat (3) step(s);
    s.rdy = 1'b1;
    step(s);
    chk("wait3_fe", {15'd0, hif.Front_Enable}, 16'd1);
    chk("wait3_sc", hif.Stall_Count, 16'd3);
    s.ramen = 1'b0;
    step(s);

    do_reset();
    s.exld = 1'b1; s.exrd = 5'd3; s.exrf = 1'b1;
    s.rs2 = 5'd3; s.u2 = 1'b1;
    s.ramen = 1'b1; s.rdy = 1'b0;
    step(s);
    chk("lu_frz_nop", {15'd0, hif.CU_Nop_Select}, 16'd0);
    s.rdy = 1'b1;
    step(s);
    chk("lu_rel_nop", {15'd0, hif.CU_Nop_Select}, 16'd1);
    idle();
    step(s);

    do_reset();
    s.ramen = 1'b1; s.rdy = 1'b0;
    repeat (16) step(s);
    chk("pre_fault", {15'd0, hif.Mem_Fault}, 16'd0);
    s.rdy = 1'b1;
    step(s);
    chk("fault_set", {15'd0, hif.Mem_Fault}, 16'd1);
    chk("fault_frz", {15'd0, hif.Back_Enable}, 16'd0);
    step(s);
    do_reset();
    step(s);
    chk("fault_clr", {15'd0, hif.Mem_Fault}, 16'd0);
    chk("sc_clr", hif.Stall_Count, 16'd0);

    for (int i = 0; i < 400; i++) begin
      s.rst   = ($urandom_range(0, 60) == 0);
      s.rs1   = 5'($urandom_range(0, 3));
      s.rs2   = 5'($urandom_range(0, 3));
      s.u1    = 1'($urandom_range(0, 1));
      s.u2    = 1'($urandom_range(0, 1));
      s.exrd  = 5'($urandom_range(0, 3));
      s.exrf  = 1'($urandom_range(0, 1));
      s.exld  = ($urandom_range(0, 3) == 0);
      s.memrd = 5'($urandom_range(0, 3));
      s.memrf = 1'($urandom_range(0, 1));
      s.wbrd  = 5'($urandom_range(0, 3));
      s.wbrf  = 1'($urandom_range(0, 1));
      s.br    = ($urandom_range(0, 4) == 0);
      s.ann   = ($urandom_range(0, 4) == 0);
      s.ramen = 1'($urandom_range(0, 1));
      s.rdy   = ($urandom_range(0, 3) != 0);
      step(s);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
